xsim_bus_arbiter: RTL

XSIM_BUS_ARBITER -- requirements
Module: xsim_bus_arbiter

---
 rtl/xsim_bus_arbiter_pkg.sv | 26 ++
 rtl/xsim_bus_arbiter_pick.sv | 47 ++++
 rtl/xsim_bus_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/xsim_bus_arbiter_pkg.sv
// Shared constants for the xsim bus arbiter: reset/hold levels, FSM encoding,
// the reserved no-owner ID and the hold-counter width.
package xsim_bus_arbiter_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic HOLD_ENABLE  = 1'b1;
  localparam logic HOLD_DISABLE = 1'b0;

  localparam int ID_W   = 5;
  localparam int HOLD_W = 8;

  localparam logic [ID_W-1:0] NO_OWNER = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;

  // Round-robin search start: one past the last owner, wrapping at num.
  function automatic logic [ID_W-1:0] rr_start(input logic [ID_W-1:0] last, input int num);
    if (int'(last) >= num - 1) return '0;
    return last + 5'd1;
  endfunction

endpackage

// File: rtl/xsim_bus_arbiter_pick.sv
// xrr_pick: stateless round-robin priority picker. The first set request at or
// after start_idx wins; if none, the search wraps to the lowest set request.
module xrr_pick
  import xsim_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 8
) (
  input  logic [NUM_MASTERS-1:0] req_in,
  input  logic [ID_W-1:0]        start_idx,
  output logic [NUM_MASTERS-1:0] onehot_out,
  output logic [ID_W-1:0]        winner_out,
  output logic                   valid_out
);

  logic            hi_found;
  logic            lo_found;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = NO_OWNER;
    lo_idx   = NO_OWNER;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (ID_W'(i) >= start_idx) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    valid_out  = lo_found;
    winner_out = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    onehot_out = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      onehot_out[i] = valid_out && (winner_out == ID_W'(i));
    end
  end

endmodule

// File: rtl/xsim_bus_arbiter.sv
// Round-robin bus arbiter with one dead TURN cycle between tenures.
// Optional hold limit with preempt pulse: define XSIMBUS_ARB_HOLD_LIMIT_EN.
module xsim_bus_arbiter
  import xsim_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 8,
  parameter int MAX_HOLD    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_in,
  input  logic [NUM_MASTERS-1:0] release_in,
  output logic [NUM_MASTERS-1:0] gnt_out,
  output logic [ID_W-1:0]        master_id_out,
  output logic                   hold_flag_out,
  output logic                   preempt_out
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 31 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
    $error("xsim_bus_arbiter: NUM_MASTERS or MAX_HOLD out of range");
  end

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        last_owner_q, last_owner_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic                   hold_flag_q, hold_flag_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_valid;
  logic                   owner_req;
  logic                   owner_rel;

  xrr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .req_in    (req_in),
    .start_idx (rr_start(last_owner_q, NUM_MASTERS)),
    .onehot_out(pick_onehot),
    .winner_out(pick_idx),
    .valid_out (pick_valid)
  );

  // The registered one-hot grant doubles as the owner mask.
  assign owner_req = |(req_in & gnt_q);
  assign owner_rel = |(release_in & gnt_q);

`ifdef XSIMBUS_ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              preempt_q, preempt_d;
  logic              limit_hit;

  assign limit_hit = (hold_cnt_q >= HOLD_W'(MAX_HOLD - 1));
`endif

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    id_d         = id_q;
    hold_flag_d  = hold_flag_q;
`ifdef XSIMBUS_ARB_HOLD_LIMIT_EN
    hold_cnt_d   = hold_cnt_q;
    preempt_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE, ST_TURN: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        id_d        = NO_OWNER;
        hold_flag_d = HOLD_DISABLE;
        if (pick_valid) begin
          state_d      = ST_OWN;
          gnt_d        = pick_onehot;
          id_d         = pick_idx;
          hold_flag_d  = HOLD_ENABLE;
          last_owner_d = pick_idx;
`ifdef XSIMBUS_ARB_HOLD_LIMIT_EN
          hold_cnt_d   = '0;
`endif
        end
      end
      ST_OWN: begin
`ifdef XSIMBUS_ARB_HOLD_LIMIT_EN
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        // Release wins over an expiring hold limit: no preempt in that case.
        if (owner_rel || !owner_req) begin
          state_d     = ST_TURN;
          gnt_d       = '0;
          id_d        = NO_OWNER;
          hold_flag_d = HOLD_DISABLE;
        end
`ifdef XSIMBUS_ARB_HOLD_LIMIT_EN
        else if (limit_hit) begin
          state_d     = ST_TURN;
          gnt_d       = '0;
          id_d        = NO_OWNER;
          hold_flag_d = HOLD_DISABLE;
          preempt_d   = 1'b1;
        end
`endif
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        id_d        = NO_OWNER;
        hold_flag_d = HOLD_DISABLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q      <= ST_IDLE;
      last_owner_q <= ID_W'(NUM_MASTERS - 1);
      gnt_q        <= '0;
      id_q         <= NO_OWNER;
      hold_flag_q  <= HOLD_DISABLE;
`ifdef XSIMBUS_ARB_HOLD_LIMIT_EN
      hold_cnt_q   <= '0;
      preempt_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      id_q         <= id_d;
      hold_flag_q  <= hold_flag_d;
`ifdef XSIMBUS_ARB_HOLD_LIMIT_EN
      hold_cnt_q   <= hold_cnt_d;
      preempt_q    <= preempt_d;
`endif
    end
  end

  assign gnt_out       = gnt_q;
  assign master_id_out = id_q;
  assign hold_flag_out = hold_flag_q;
`ifdef XSIMBUS_ARB_HOLD_LIMIT_EN
  assign preempt_out   = preempt_q;
`else
  assign preempt_out   = 1'b0;
`endif

endmodule
